// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI mode-0 responder
package spi_pkg;

  localparam int             SPI_BYTE_W        = 8;
  localparam logic [7:0]     IDLE_BYTE_DEFAULT = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_8bit_if.sv
// rtl/spi_slave_8bit_if.sv - SPI pins plus parallel TX/RX handshake bundle
interface spi_slave_8bit_if;
  import spi_pkg::*;

  logic                  sclk;
  logic                  mosi;
  logic                  ss_n;
  logic                  miso;
  logic                  miso_oe;
  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_wr;
  logic                  tx_ready;
  logic [SPI_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ack;
  logic                  overrun;

  modport master (
    output sclk, mosi, ss_n, tx_data, tx_wr, rx_ack,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, overrun
  );

  modport slave (
    input  sclk, mosi, ss_n, tx_data, tx_wr, rx_ack,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, overrun
  );

endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulses
// Edges compare the synchronized value against one further registered copy.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_8bit.sv
// rtl/spi_slave_8bit.sv - oversampled SPI mode-0 responder, MSB first
// Receives on MOSI into RX_DATA (valid/ack) while shifting a buffered TX byte out on MISO.
module spi_slave_8bit
  import spi_pkg::*;
#(
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT,
  parameter int                    SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              clr,
  spi_slave_8bit_if.slave  bus
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk (clk), .clr (clr), .din (bus.sclk),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk (clk), .clr (clr), .din (bus.ss_n),
    .dout(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk (clk), .clr (clr), .din (bus.mosi),
    .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  got_rise_q, got_rise_d;
  logic [SPI_BYTE_W-1:0] rx_sr_q, rx_sr_d;
  logic [SPI_BYTE_W-1:0] tx_sr_q, tx_sr_d;
  logic [SPI_BYTE_W-1:0] tx_buf_q, tx_buf_d;
  logic                  tx_full_q, tx_full_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;

  logic                  complete;
  logic                  consume;
  logic                  tx_write;
  logic [SPI_BYTE_W-1:0] tx_next_byte;
  logic                  sclk_level_unused;
  logic                  ss_level_unused;

  assign sclk_level_unused = sclk_s;
  assign ss_level_unused   = ss_s;
  assign tx_next_byte      = tx_full_q ? tx_buf_q : IDLE_BYTE;
  assign tx_write          = bus.tx_wr & ~tx_full_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      got_rise_q <= 1'b0;
      rx_sr_q    <= '0;
      tx_sr_q    <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      got_rise_q <= got_rise_d;
      rx_sr_q    <= rx_sr_d;
      tx_sr_q    <= tx_sr_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    got_rise_d = got_rise_q;
    rx_sr_d    = rx_sr_q;
    tx_sr_d    = tx_sr_q;
    complete   = 1'b0;
    consume    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d    = ST_SHIFT;
          tx_sr_d    = tx_next_byte;
          consume    = 1'b1;
          bit_cnt_d  = 3'd0;
          got_rise_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          rx_sr_d    = {rx_sr_q[SPI_BYTE_W-2:0], mosi_s};
          got_rise_d = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            complete  = 1'b1;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (sclk_fall && got_rise_q && !ss_rise) begin
          // bit_cnt wraps to 0 after the 8th sample, so a falling edge there is a byte boundary
          if (bit_cnt_q == 3'd0) begin
            tx_sr_d = tx_next_byte;
            consume = 1'b1;
          end else begin
            tx_sr_d = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
          end
        end
        if (ss_rise) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = 3'd0;
          got_rise_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (complete) begin
      rx_data_d  = {rx_sr_q[SPI_BYTE_W-2:0], mosi_s};
      rx_valid_d = 1'b1;
      if (rx_valid_q && !bus.rx_ack) begin
        overrun_d = 1'b1;
      end
    end else if (bus.rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  // A write accepted alongside a consume refills the buffer after the old contents leave
  always_comb begin
    tx_buf_d  = tx_write ? bus.tx_data : tx_buf_q;
    tx_full_d = tx_full_q;
    if (tx_write) begin
      tx_full_d = 1'b1;
    end else if (consume) begin
      tx_full_d = 1'b0;
    end
  end

  // MISO is registered from next-state values so it is valid one cycle after the SS_N fall pulse
  always_comb begin
    miso_oe_d = (state_d == ST_SHIFT);
    miso_d    = miso_oe_d & tx_sr_d[SPI_BYTE_W-1];
  end

  assign bus.miso     = miso_q;
  assign bus.miso_oe  = miso_oe_q;
  assign bus.tx_ready = ~tx_full_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_8bit.sv
// tb/tb_spi_slave_8bit.sv - directed bench acting as an SPI mode-0 master
module tb_spi_slave_8bit;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;
  logic [7:0] got;
  logic [7:0] got2;

  spi_slave_8bit_if bus();

  spi_slave_8bit #(.IDLE_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_wr   = 1'b1;
    clks(1);
    bus.tx_wr   = 1'b0;
    clks(1);
  endtask

  task automatic rx_ack_pulse();
    bus.rx_ack = 1'b1;
    clks(1);
    bus.rx_ack = 1'b0;
    clks(1);
  endtask

  task automatic ss_low();
    bus.ss_n = 1'b0;
    clks(HALF);
    check("miso_oe_selected", {7'd0, bus.miso_oe}, 8'd1);
  endtask

  task automatic ss_high();
    clks(HALF);
    bus.ss_n = 1'b1;
    clks(HALF);
  endtask

  // Sends nbits of mo MSB first; the master samples MISO just before each rising edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit ack_last,
                      output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[7-i];
      clks(HALF);
      mi = {mi[6:0], bus.miso};
      bus.sclk = 1'b1;
      if (ack_last && i == 7) begin
        clks(2);
        bus.rx_ack = 1'b1;
        clks(1);
        bus.rx_ack = 1'b0;
        clks(HALF - 3);
      end else begin
        clks(HALF);
      end
      bus.sclk = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_miso"},     {7'd0, bus.miso},     8'd0);
    check({pfx, "_miso_oe"},  {7'd0, bus.miso_oe},  8'd0);
    check({pfx, "_tx_ready"}, {7'd0, bus.tx_ready}, 8'd1);
    check({pfx, "_rx_data"},  bus.rx_data,          8'h00);
    check({pfx, "_rx_valid"}, {7'd0, bus.rx_valid}, 8'd0);
    check({pfx, "_overrun"},  {7'd0, bus.overrun},  8'd0);
  endtask

  initial begin
    bus.sclk    = 1'b0;
    bus.mosi    = 1'b0;
    bus.ss_n    = 1'b1;
    bus.tx_data = 8'h00;
    bus.tx_wr   = 1'b0;
    bus.rx_ack  = 1'b0;
    clr         = 1'b0;
    clks(3);
    check_reset_state("rst");
    clr = 1'b1;
    clks(4);

    // Buffered A5 goes out while 3C comes in
    tx_write(8'hA5);
    check("a5_tx_ready_after_wr", {7'd0, bus.tx_ready}, 8'd0);
    ss_low();
    check("a5_tx_ready_after_load", {7'd0, bus.tx_ready}, 8'd1);
    xfer(8'h3C, 8, 1'b0, got);
    ss_high();
    check("a5_miso", got, 8'hA5);
    check("a5_rx_data", bus.rx_data, 8'h3C);
    check("a5_rx_valid", {7'd0, bus.rx_valid}, 8'd1);
    check("a5_overrun", {7'd0, bus.overrun}, 8'd0);
    check("a5_miso_oe_idle", {7'd0, bus.miso_oe}, 8'd0);
    rx_ack_pulse();
    check("a5_rx_valid_acked", {7'd0, bus.rx_valid}, 8'd0);

    // Reset in the middle of a byte with a full TX buffer and stale RX data
    tx_write(8'h77);
    ss_low();
    xfer(8'hF0, 4, 1'b0, got);
    #3 clr = 1'b0;
    #1 check_reset_state("midrst");
    bus.ss_n = 1'b1;
    bus.sclk = 1'b0;
    clks(3);
    clr = 1'b1;
    clks(4);
    ss_low();
    xfer(8'h96, 8, 1'b0, got);
    ss_high();
    check("post_rst_miso", got, 8'hFF);
    check("post_rst_rx_data", bus.rx_data, 8'h96);
    check("post_rst_rx_valid", {7'd0, bus.rx_valid}, 8'd1);
    rx_ack_pulse();

    // Two bytes in one select window, no acknowledge in between
    ss_low();
    xfer(8'h01, 8, 1'b0, got);
    xfer(8'h80, 8, 1'b0, got2);
    ss_high();
    check("b2b_miso_0", got, 8'hFF);
    check("b2b_miso_1", got2, 8'hFF);
    check("b2b_rx_data", bus.rx_data, 8'h80);
    check("b2b_rx_valid", {7'd0, bus.rx_valid}, 8'd1);
    check("b2b_overrun", {7'd0, bus.overrun}, 8'd1);
    rx_ack_pulse();
    check("b2b_rx_valid_acked", {7'd0, bus.rx_valid}, 8'd0);
    check("b2b_overrun_acked", {7'd0, bus.overrun}, 8'd0);

    // Abort after five bits, then a clean byte
    ss_low();
    xfer(8'hFF, 5, 1'b0, got);
    ss_high();
    check("abort_rx_valid", {7'd0, bus.rx_valid}, 8'd0);
    check("abort_miso_oe", {7'd0, bus.miso_oe}, 8'd0);
    check("abort_miso", {7'd0, bus.miso}, 8'd0);
    ss_low();
    xfer(8'h5A, 8, 1'b0, got);
    ss_high();
    check("abort_next_rx_data", bus.rx_data, 8'h5A);
    check("abort_next_rx_valid", {7'd0, bus.rx_valid}, 8'd1);
    check("abort_next_miso", got, 8'hFF);
    rx_ack_pulse();

    // Acknowledge lands in the completion cycle of the second byte
    ss_low();
    xfer(8'h12, 8, 1'b0, got);
    xfer(8'hC3, 8, 1'b1, got2);
    ss_high();
    check("ackcmp_rx_valid", {7'd0, bus.rx_valid}, 8'd1);
    check("ackcmp_rx_data", bus.rx_data, 8'hC3);
    check("ackcmp_overrun", {7'd0, bus.overrun}, 8'd0);
    rx_ack_pulse();

    // Second write while the buffer is full is dropped
    tx_write(8'h11);
    check("dblwr_tx_ready_1", {7'd0, bus.tx_ready}, 8'd0);
    tx_write(8'h22);
    check("dblwr_tx_ready_2", {7'd0, bus.tx_ready}, 8'd0);
    ss_low();
    xfer(8'h00, 8, 1'b0, got);
    ss_high();
    check("dblwr_miso", got, 8'h11);
    check("dblwr_tx_ready_end", {7'd0, bus.tx_ready}, 8'd1);
    check("dblwr_rx_data", bus.rx_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
